// File: rtl/shifter_if.sv
// Purpose : host + SPI pin bundle for the byte-wide SPI mode-0 shift engine.
// Ports   : host side start_write/start_read/data_in/speed in, data_out/busy out;
//           SPI side miso in, mosi/sclk out. The slave modport is the engine's view.
interface shifter_if;
  logic       start_write;
  logic       start_read;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [1:0] speed;
  logic       busy;
  logic       miso;
  logic       mosi;
  logic       sclk;

  // Engine side
  modport slave (
    input  start_write, start_read, data_in, speed, miso,
    output data_out, busy, mosi, sclk
  );

  // Host / SPI-slave side
  modport master (
    output start_write, start_read, data_in, speed, miso,
    input  data_out, busy, mosi, sclk
  );
endinterface

// File: rtl/shifter.sv
// Purpose : SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit transfers.
// Latency : busy rises one clk after the start pulse and stays high for 16*2^speed clks;
//           data_out updates on the edge busy falls (reads only).
// Backpressure: none; start pulses arriving while busy are dropped.
// Ports   : clk, rst (async active-high); bus (shifter_if.slave) carries host and SPI pins.
module shifter (
  input  logic      clk,
  input  logic      rst,
  shifter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;        // cycles spent in the current phase
  logic [2:0] half_q, half_d;      // phase length minus one, latched at start
  logic [2:0] bit_q, bit_d;        // bit index 0..7 of the transfer
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] data_out_q, data_out_d;
  logic       is_read_q, is_read_d;
  logic       mosi_q, mosi_d;
  logic       sclk_q, sclk_d;
  logic       busy_q, busy_d;

  logic [2:0] half_sel;
  logic [7:0] tx_load;

  always_comb begin
    half_sel = 3'd0;
    case (bus.speed)
      2'd0: half_sel = 3'd0;
      2'd1: half_sel = 3'd1;
      2'd2: half_sel = 3'd3;
      2'd3: half_sel = 3'd7;
      default: half_sel = 3'd0;
    endcase
  end

  // A read clocks out all ones so the slave sees an idle-high line.
  assign tx_load = bus.start_write ? bus.data_in : 8'hFF;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    is_read_d  = is_read_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_write || bus.start_read) begin
          state_d   = ST_LOW;
          busy_d    = 1'b1;
          cnt_d     = 3'd0;
          bit_d     = 3'd0;
          half_d    = half_sel;
          // write wins when both pulses coincide
          is_read_d = ~bus.start_write;
          tx_d      = tx_load;
          mosi_d    = tx_load[7];
          rx_d      = 8'h00;
        end
      end

      ST_LOW: begin
        if (cnt_q == half_q) begin
          // rising sclk: slave data has been stable since the previous falling edge
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          cnt_d   = 3'd0;
          rx_d    = {rx_q[6:0], bus.miso};
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_HIGH: begin
        if (cnt_q == half_q) begin
          sclk_d = 1'b0;
          cnt_d  = 3'd0;
          if (bit_q == 3'd7) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            mosi_d  = 1'b1;
            if (is_read_q) begin
              data_out_d = rx_q;
            end
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      half_q     <= 3'd0;
      bit_q      <= 3'd0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      data_out_q <= 8'h00;
      is_read_q  <= 1'b0;
      mosi_q     <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      is_read_q  <= is_read_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;
  assign bus.mosi     = mosi_q;
  assign bus.sclk     = sclk_q;

endmodule

// File: tb/tb_shifter.sv
// Purpose : self-checking bench for the SPI mode-0 shift engine.
// Ports   : none; drives a shifter_if instance and plays the SPI slave on miso.
module tb_shifter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shifter_if bus ();

  shifter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    logic [7:0] miso_b;
    logic [1:0] spd;
    logic [7:0] exp_dout;
    logic [7:0] exp_mosi;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transfer: pulse start, act as SPI slave, measure and compare.
  // inject_at >= 0 pulses both starts again at that busy cycle (must be ignored).
  task automatic run_xfer(input bit wr, input bit rd, input logic [7:0] din,
                          input logic [7:0] miso_b, input logic [1:0] spd,
                          input logic [7:0] exp_dout, input logic [7:0] exp_mosi,
                          input int exp_len, input int inject_at, input string tag);
    int         len, pulses, per_bad, stab_bad, dout_bad, last_rise, cyc;
    logic       prev_sclk, prev_mosi;
    logic [7:0] mosi_seq, sh, dout0;
    len = 0; pulses = 0; per_bad = 0; stab_bad = 0; dout_bad = 0; last_rise = 0; cyc = 0;
    mosi_seq = 8'h00;
    sh = miso_b;
    dout0 = bus.data_out;
    @(negedge clk);
    bus.start_write = wr;
    bus.start_read  = rd;
    bus.data_in     = din;
    bus.speed       = spd;
    bus.miso        = sh[7];
    @(negedge clk);
    bus.start_write = 1'b0;
    bus.start_read  = 1'b0;
    bus.data_in     = ~din;     // only the start edge may capture data_in
    bus.speed       = ~spd;     // speed must be held internally
    chk({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    prev_sclk = bus.sclk;
    prev_mosi = bus.mosi;
    while (bus.busy && cyc < 400) begin
      len++;
      if (bus.data_out !== dout0) dout_bad++;
      if (bus.sclk && !prev_sclk) begin
        pulses++;
        if (pulses <= 8) mosi_seq = {mosi_seq[6:0], bus.mosi};
        if (pulses > 1 && (cyc - last_rise) != (2 << spd)) per_bad++;
        last_rise = cyc;
      end
      if (!bus.sclk && prev_sclk) begin
        sh = {sh[6:0], 1'b1};
        bus.miso = sh[7];
      end else if (bus.mosi !== prev_mosi) begin
        stab_bad++;
      end
      prev_sclk = bus.sclk;
      prev_mosi = bus.mosi;
      bus.start_write = (cyc == inject_at);
      bus.start_read  = (cyc == inject_at);
      bus.data_in     = 8'h5A;
      cyc++;
      @(negedge clk);
    end
    bus.start_write = 1'b0;
    bus.start_read  = 1'b0;
    chk({tag, " busy_len"}, 32'(len), 32'(exp_len));
    chk({tag, " sclk_pulses"}, 32'(pulses), 32'd8);
    chk({tag, " sclk_period_errs"}, 32'(per_bad), 32'd0);
    chk({tag, " mosi_bits"}, 32'(mosi_seq), 32'(exp_mosi));
    chk({tag, " mosi_unstable"}, 32'(stab_bad), 32'd0);
    chk({tag, " dout_during_xfer"}, 32'(dout_bad), 32'd0);
    chk({tag, " data_out"}, 32'(bus.data_out), 32'(exp_dout));
    chk({tag, " idle_sclk_mosi"}, 32'({bus.sclk, bus.mosi}), 32'b01);
    repeat (3) @(negedge clk);
    chk({tag, " stays_idle"}, 32'({bus.busy, bus.sclk}), 32'b00);
  endtask

  logic [7:0] model_dout;
  int         idle_bad;

  initial begin
    errors = 0;
    checks = 0;
    bus.start_write = 1'b0;
    bus.start_read  = 1'b0;
    bus.data_in     = 8'h00;
    bus.speed       = 2'd2;
    bus.miso        = 1'b0;
    rst = 1'b1;

    vecs[0] = '{1'b1, 1'b0, 8'h81, 8'h00, 2'd2, 8'h00, 8'h81, 64};
    vecs[1] = '{1'b1, 1'b0, 8'h55, 8'hFF, 2'd2, 8'h00, 8'h55, 64};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h81, 2'd2, 8'h81, 8'hFF, 64};
    vecs[3] = '{1'b0, 1'b1, 8'h12, 8'hC3, 2'd0, 8'hC3, 8'hFF, 16};
    vecs[4] = '{1'b0, 1'b1, 8'h34, 8'hC3, 2'd3, 8'hC3, 8'hFF, 128};
    vecs[5] = '{1'b1, 1'b1, 8'h3C, 8'hA5, 2'd1, 8'hC3, 8'h3C, 32};
    vecs[6] = '{1'b1, 1'b0, 8'h0F, 8'h96, 2'd1, 8'hC3, 8'h0F, 32};

    #1;
    chk("reset_outputs", 32'({bus.sclk, bus.busy, bus.mosi, bus.data_out}), 32'h0_1_00 | 32'h100);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sclk !== 1'b0 || bus.busy !== 1'b0 || bus.mosi !== 1'b1) idle_bad++;
    end
    chk("idle_no_activity", 32'(idle_bad), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_xfer(vecs[i].wr, vecs[i].rd, vecs[i].din, vecs[i].miso_b, vecs[i].spd,
               vecs[i].exp_dout, vecs[i].exp_mosi, vecs[i].exp_len, -1,
               $sformatf("vec%0d", i));
    end

    // Starts while busy are dropped: transfer keeps its own byte, speed and length.
    run_xfer(1'b1, 1'b0, 8'hAA, 8'h00, 2'd0, 8'hC3, 8'hAA, 16, 3, "ign_start");

    // Reset in the middle of a read aborts it with no data_out update.
    @(negedge clk);
    bus.start_read = 1'b1;
    bus.speed      = 2'd2;
    bus.miso       = 1'b1;
    @(negedge clk);
    bus.start_read = 1'b0;
    repeat (20) @(negedge clk);
    chk("midread_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midread_reset_outputs", 32'({bus.sclk, bus.busy, bus.mosi, bus.data_out}), 32'h100);
    @(negedge clk);
    rst = 1'b0;
    run_xfer(1'b0, 1'b1, 8'h00, 8'h5A, 2'd1, 8'h5A, 8'hFF, 32, -1, "after_reset");

    // Randomised transfers against a rule-level model.
    model_dout = 8'h5A;
    for (int i = 0; i < 12; i++) begin
      bit         wr, rd;
      logic [7:0] din, mb, exp_mosi;
      logic [1:0] spd;
      int         mode;
      mode = int'($urandom_range(0, 2));
      wr   = (mode != 1);
      rd   = (mode != 0);
      din  = 8'($urandom);
      mb   = 8'($urandom);
      spd  = 2'($urandom_range(0, 3));
      if (wr) begin
        exp_mosi = din;
      end else begin
        exp_mosi   = 8'hFF;
        model_dout = mb;
      end
      run_xfer(wr, rd, din, mb, spd, model_dout, exp_mosi, 16 * (1 << spd), -1,
               $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
